hazard_unit_vl: RTL and testbench

// - Parametrised successor to the 5-stage hazard/forwarding control: RAW forwarding, load-use stall, branch flush, plus

---
 rtl/osiris_pkg.sv | 18 +
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_unit_vl.sv | 185 ++++++++++++++++++
 tb/tb_hazard_unit_vl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/osiris_pkg.sv
// Shared encodings for the hazard/forwarding control block.
package osiris_pkg;

  // Result-source code that marks a load in EX.
  localparam logic [1:0] RESULT_LOAD = 2'b01;

  // Forward-select encodings for the EX operand muxes.
  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_M    = 2'b10;

  // Variable-latency data-memory wait tracker states.
  typedef enum logic {
    MW_IDLE = 1'b0,
    MW_WAIT = 1'b1
  } memwait_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  output logic [CNT_WIDTH-1:0] o_count
);

  // Count increments, holding once every bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_count <= '0;
    end else if (i_inc && (o_count != {CNT_WIDTH{1'b1}})) begin
      o_count <= o_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_unit_vl.sv
// Pipeline hazard control: RAW forwarding, load-use stall, branch flush,
// full-pipe freeze while data memory is busy (with timeout), perf counters.
//
// Handshake: i_mem_req_M with i_mem_ready high in the same cycle completes
// the access with no freeze. Otherwise the pipe freezes from the request
// cycle through the cycle in which i_mem_ready is seen high (inclusive),
// or until MEM_TIMEOUT wait cycles elapse, which sets sticky o_mem_err.
module hazard_unit_vl
  import osiris_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 4,
  parameter int MEM_TIMEOUT    = 255,
  parameter int TMR_WIDTH      = 8,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1Addr_ID,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2Addr_ID,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs1Addr_EX,
  input  logic [REG_ADDR_WIDTH-1:0] i_rs2Addr_EX,
  input  logic [REG_ADDR_WIDTH-1:0] i_rdAddr_EX,
  input  logic [1:0]                i_result_src_EX,
  input  logic                      i_pcSrc_EX,
  input  logic [REG_ADDR_WIDTH-1:0] i_rdAddr_M,
  input  logic                      i_reg_write_M,
  input  logic                      i_mem_req_M,
  input  logic                      i_mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_rdAddr_WB,
  input  logic                      i_reg_write_WB,
  output logic                      o_stall_IF,
  output logic                      o_stall_ID,
  output logic                      o_stall_EX,
  output logic                      o_stall_M,
  output logic                      o_flush_ID,
  output logic                      o_flush_EX,
  output logic                      o_flush_WB,
  output logic [1:0]                o_forward_rs1_EX,
  output logic [1:0]                o_forward_rs2_EX,
  output logic                      o_mem_err,
  output logic [CNT_WIDTH-1:0]      o_stall_cnt,
  output logic [CNT_WIDTH-1:0]      o_flush_cnt,
  output logic [CNT_WIDTH-1:0]      o_memwait_cnt
);

  localparam logic [TMR_WIDTH-1:0] TIMEOUT_VAL = TMR_WIDTH'(MEM_TIMEOUT);

  // Wait tracker state; mw_state is the probe point for FSM checkers.
  memwait_state_e             mw_state;
  memwait_state_e             mw_state_nx;
  logic [TMR_WIDTH-1:0]       timer;
  logic [TMR_WIDTH-1:0]       timer_nx;
  logic                       err_set;
  logic                       freeze;

  logic                       m_fwd_ok;
  logic                       wb_fwd_ok;
  logic                       load_use;
  logic                       branch;
  logic                       stall_inc;
  logic                       flush_inc;

  // Forward candidates: a writing stage with a non-x0 destination.
  assign m_fwd_ok  = i_reg_write_M  && (i_rdAddr_M  != '0);
  assign wb_fwd_ok = i_reg_write_WB && (i_rdAddr_WB != '0);

  // Load in EX whose destination feeds an instruction sitting in ID.
  assign load_use = (i_result_src_EX == RESULT_LOAD) && (i_rdAddr_EX != '0) &&
                    ((i_rdAddr_EX == i_rs1Addr_ID) || (i_rdAddr_EX == i_rs2Addr_ID));
  assign branch   = i_pcSrc_EX;

  // Wait tracker register, timer and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      mw_state  <= MW_IDLE;
      timer     <= '0;
      o_mem_err <= 1'b0;
    end else begin
      mw_state <= mw_state_nx;
      timer    <= timer_nx;
      if (err_set) begin
        o_mem_err <= 1'b1;
      end
    end
  end

  // Next state, timer and freeze decision for the memory wait tracker.
  always_comb begin
    mw_state_nx = mw_state;
    timer_nx    = timer;
    err_set     = 1'b0;
    freeze      = 1'b0;
    case (mw_state)
      MW_IDLE: begin
        if (i_mem_req_M && !i_mem_ready) begin
          freeze      = 1'b1;
          mw_state_nx = MW_WAIT;
          timer_nx    = TMR_WIDTH'(1);
        end
      end
      MW_WAIT: begin
        // Freeze holds through the ready cycle so data latches next edge.
        freeze = 1'b1;
        if (i_mem_ready) begin
          mw_state_nx = MW_IDLE;
        end else if (timer == TIMEOUT_VAL) begin
          err_set     = 1'b1;
          mw_state_nx = MW_IDLE;
        end else begin
          timer_nx = timer + TMR_WIDTH'(1);
        end
      end
      default: begin
        mw_state_nx = MW_IDLE;
      end
    endcase
  end

  // Stall/flush/forward drive: reset bubbles, then freeze, then branch/load-use.
  always_comb begin
    o_stall_IF       = 1'b0;
    o_stall_ID       = 1'b0;
    o_stall_EX       = 1'b0;
    o_stall_M        = 1'b0;
    o_flush_ID       = 1'b0;
    o_flush_EX       = 1'b0;
    o_flush_WB       = 1'b0;
    o_forward_rs1_EX = FWD_NONE;
    o_forward_rs2_EX = FWD_NONE;
    if (rst) begin
      o_flush_ID = 1'b1;
      o_flush_EX = 1'b1;
      o_flush_WB = 1'b1;
    end else begin
      if (m_fwd_ok && (i_rdAddr_M == i_rs1Addr_EX)) begin
        o_forward_rs1_EX = FWD_M;
      end else if (wb_fwd_ok && (i_rdAddr_WB == i_rs1Addr_EX)) begin
        o_forward_rs1_EX = FWD_WB;
      end
      if (m_fwd_ok && (i_rdAddr_M == i_rs2Addr_EX)) begin
        o_forward_rs2_EX = FWD_M;
      end else if (wb_fwd_ok && (i_rdAddr_WB == i_rs2Addr_EX)) begin
        o_forward_rs2_EX = FWD_WB;
      end
      if (freeze) begin
        o_stall_IF = 1'b1;
        o_stall_ID = 1'b1;
        o_stall_EX = 1'b1;
        o_stall_M  = 1'b1;
        o_flush_WB = 1'b1;
      end else begin
        // A taken branch discards the stalled instruction, so it wins.
        o_stall_IF = load_use && !branch;
        o_stall_ID = load_use && !branch;
        o_flush_ID = branch;
        o_flush_EX = branch || load_use;
      end
    end
  end

  assign stall_inc = load_use && !branch && !freeze;
  assign flush_inc = branch && !freeze;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (stall_inc),
    .o_count (o_stall_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (flush_inc),
    .o_count (o_flush_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_memwait_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (freeze),
    .o_count (o_memwait_cnt)
  );

endmodule

// File: tb/tb_hazard_unit_vl.sv
// Bench for hazard_unit_vl: directed scenarios plus random traffic,
// all checked against a cycle-level behavioural reference model.
module tb_hazard_unit_vl;

  localparam int RW  = 5;
  localparam int TMO = 4;
  localparam int CW  = 6;
  localparam int CMAX = (1 << CW) - 1;

  // Clock/reset block.
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [RW-1:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_m, rd_wb;
  logic [1:0]    result_src_ex;
  logic          pcsrc_ex, reg_write_m, mem_req_m, mem_ready, reg_write_wb;
  logic          stall_if, stall_id, stall_ex, stall_m;
  logic          flush_id, flush_ex, flush_wb, mem_err;
  logic [1:0]    fwd1, fwd2;
  logic [CW-1:0] stall_cnt, flush_cnt, memwait_cnt;

  hazard_unit_vl #(
    .REG_ADDR_WIDTH (RW),
    .MEM_TIMEOUT    (TMO),
    .TMR_WIDTH      (8),
    .CNT_WIDTH      (CW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_rs1Addr_ID     (rs1_id),
    .i_rs2Addr_ID     (rs2_id),
    .i_rs1Addr_EX     (rs1_ex),
    .i_rs2Addr_EX     (rs2_ex),
    .i_rdAddr_EX      (rd_ex),
    .i_result_src_EX  (result_src_ex),
    .i_pcSrc_EX       (pcsrc_ex),
    .i_rdAddr_M       (rd_m),
    .i_reg_write_M    (reg_write_m),
    .i_mem_req_M      (mem_req_m),
    .i_mem_ready      (mem_ready),
    .i_rdAddr_WB      (rd_wb),
    .i_reg_write_WB   (reg_write_wb),
    .o_stall_IF       (stall_if),
    .o_stall_ID       (stall_id),
    .o_stall_EX       (stall_ex),
    .o_stall_M        (stall_m),
    .o_flush_ID       (flush_id),
    .o_flush_EX       (flush_ex),
    .o_flush_WB       (flush_wb),
    .o_forward_rs1_EX (fwd1),
    .o_forward_rs2_EX (fwd2),
    .o_mem_err        (mem_err),
    .o_stall_cnt      (stall_cnt),
    .o_flush_cnt      (flush_cnt),
    .o_memwait_cnt    (memwait_cnt)
  );

  // Scoreboard counters.
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state: cycles already spent waiting on the current
  // memory access (0 = none outstanding), sticky error, event tallies.
  int m_waited = 0;
  int m_err    = 0;
  int m_stall  = 0;
  int m_flush  = 0;
  int m_mw     = 0;

  function automatic int sat_inc(input int v);
    return (v < CMAX) ? v + 1 : v;
  endfunction

  function automatic logic [1:0] ref_fwd(input logic [RW-1:0] rs);
    if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
    if (reg_write_wb && rd_wb != 0 && rd_wb == rs) return 2'b01;
    return 2'b00;
  endfunction

  // One clock: compare at negedge, advance model to next edge, then drive.
  task automatic step(input string tag);
    logic       lu, br, frz;
    logic [6:0] exp_ctl;
    logic [1:0] e1, e2;
    @(negedge clk);
    lu  = (result_src_ex == 2'b01) && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id);
    br  = pcsrc_ex;
    frz = (m_waited > 0) || (mem_req_m && !mem_ready);
    e1  = ref_fwd(rs1_ex);
    e2  = ref_fwd(rs2_ex);
    if (rst) begin
      exp_ctl = 7'b0000_111;
      e1 = 2'b00;
      e2 = 2'b00;
    end else if (frz) begin
      exp_ctl = 7'b1111_001;
    end else begin
      exp_ctl = {lu && !br, lu && !br, 1'b0, 1'b0, br, br || lu, 1'b0};
    end
    check({tag, ".ctl"}, {25'd0, stall_if, stall_id, stall_ex, stall_m, flush_id, flush_ex, flush_wb},
          {25'd0, exp_ctl});
    check({tag, ".fwd1"}, {30'd0, fwd1}, {30'd0, e1});
    check({tag, ".fwd2"}, {30'd0, fwd2}, {30'd0, e2});
    check({tag, ".err"}, {31'd0, mem_err}, 32'(m_err));
    check({tag, ".stall_cnt"}, {26'd0, stall_cnt}, 32'(m_stall));
    check({tag, ".flush_cnt"}, {26'd0, flush_cnt}, 32'(m_flush));
    check({tag, ".memwait_cnt"}, {26'd0, memwait_cnt}, 32'(m_mw));
    if (rst) begin
      m_waited = 0; m_err = 0; m_stall = 0; m_flush = 0; m_mw = 0;
    end else begin
      if (lu && !br && !frz) m_stall = sat_inc(m_stall);
      if (br && !frz)        m_flush = sat_inc(m_flush);
      if (frz) begin
        m_mw = sat_inc(m_mw);
        if (m_waited == 0)        m_waited = 1;
        else if (mem_ready)       m_waited = 0;
        else if (m_waited == TMO) begin m_err = 1; m_waited = 0; end
        else                      m_waited++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Driver: return all pipeline inputs to a quiet state.
  task automatic clear_inputs();
    rs1_id = '0; rs2_id = '0; rs1_ex = '0; rs2_ex = '0; rd_ex = '0;
    rd_m = '0; rd_wb = '0; result_src_ex = 2'b00; pcsrc_ex = 1'b0;
    reg_write_m = 1'b0; mem_req_m = 1'b0; mem_ready = 1'b0; reg_write_wb = 1'b0;
  endtask

  function automatic logic [RW-1:0] rnd_addr();
    logic [RW-1:0] a;
    a = RW'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) a[RW-1] = 1'b1;
    return a;
  endfunction

  initial begin
    clear_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    step("reset");
    rst = 1'b0;

    // Forwarding priority, x0 and upper-bit compares.
    rd_m = 5; reg_write_m = 1; rd_wb = 5; reg_write_wb = 1; rs1_ex = 5;
    step("fwd_m");
    reg_write_m = 0;
    step("fwd_wb");
    clear_inputs(); reg_write_m = 1; reg_write_wb = 1;
    step("fwd_x0");
    rd_m = 5'h13; rs2_ex = 5'h03; rs1_ex = 5'h13;
    step("fwd_hi");

    // Load-use stall, then release.
    clear_inputs(); result_src_ex = 2'b01; rd_ex = 3; rs2_id = 3;
    step("lu");
    clear_inputs();
    step("lu_after");

    // Branch beats load-use.
    result_src_ex = 2'b01; rd_ex = 3; rs1_id = 3; pcsrc_ex = 1;
    step("lu_br");
    clear_inputs();

    // Four-cycle memory wait.
    mem_req_m = 1;
    for (int i = 0; i < 3; i++) step("mw_wait");
    mem_ready = 1;
    step("mw_ready");
    clear_inputs();
    step("mw_done");

    // Branch held during wait is applied the first unfrozen cycle.
    mem_req_m = 1; pcsrc_ex = 1;
    step("br_frz0");
    step("br_frz1");
    mem_ready = 1;
    step("br_frz_rdy");
    mem_req_m = 0; mem_ready = 0;
    step("br_release");
    clear_inputs();

    // Timeout and sticky error.
    mem_req_m = 1;
    for (int i = 0; i < 5; i++) step("tmo");
    mem_req_m = 0;
    step("tmo_after0");
    step("tmo_after1");

    // Reset in the middle of a wait.
    mem_req_m = 1;
    step("rstw0");
    step("rstw1");
    rst = 1;
    step("rstw_rst");
    rst = 0;
    clear_inputs();
    step("rstw_idle");

    // Zero-latency access behaves like a fixed-latency pipe.
    mem_req_m = 1; mem_ready = 1; result_src_ex = 2'b01; rd_ex = 7; rs1_id = 7;
    step("zero_lat");
    clear_inputs();

    // Drive flush counter into saturation.
    pcsrc_ex = 1;
    for (int i = 0; i < CMAX + 5; i++) step("sat");
    clear_inputs();

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      rs1_id        = rnd_addr();
      rs2_id        = rnd_addr();
      rs1_ex        = rnd_addr();
      rs2_ex        = rnd_addr();
      rd_ex         = rnd_addr();
      rd_m          = rnd_addr();
      rd_wb         = rnd_addr();
      result_src_ex = 2'($urandom_range(0, 3));
      pcsrc_ex      = ($urandom_range(0, 4) == 0);
      reg_write_m   = 1'($urandom_range(0, 1));
      reg_write_wb  = 1'($urandom_range(0, 1));
      mem_req_m     = ($urandom_range(0, 9) < 3);
      mem_ready     = 1'($urandom_range(0, 1));
      step("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
